// File: rtl/axis_batch_pkg.sv
// Shared constants, FSM encoding and sizing helpers
// for the C2H batch packer.
package axis_batch_pkg;

  localparam int HDR_W = 8;

  localparam int IDLE_B = 0;
  localparam int LOAD_B = 1;
  localparam int SEND_B = 2;
  localparam int REL_B  = 3;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_LOAD = 4'b0010;
  localparam logic [3:0] ST_SEND = 4'b0100;
  localparam logic [3:0] ST_REL  = 4'b1000;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int beats_f(input int dw, input int aw);
    return (dw + HDR_W + aw - 1) / aw;
  endfunction

endpackage

// File: rtl/batch_bank_store.sv
// Record storage for all banks: one write port and
// one registered read port.
module batch_bank_store
  import axis_batch_pkg::*;
#(
  parameter int DATA_WIDTH     = 16000,
  parameter int PKTS_PER_BATCH = 8,
  parameter int NUM_BANKS      = 2,
  parameter int BANK_W         = clog2_f(NUM_BANKS),
  parameter int IDX_W          = clog2_f(PKTS_PER_BATCH + 1)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BANK_W-1:0]     wbank,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BANK_W-1:0]     rbank,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = NUM_BANKS * PKTS_PER_BATCH;
  localparam int AW    = clog2_f(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;

  assign waddr = AW'(wbank) * AW'(PKTS_PER_BATCH)
               + AW'(widx);
  assign raddr = AW'(rbank) * AW'(PKTS_PER_BATCH)
               + AW'(ridx);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_batch_packer.sv
// Packs core records into banked batches and streams each
// sealed bank to XDMA C2H as one tlast-terminated burst.
module axis_batch_packer
  import axis_batch_pkg::*;
#(
  parameter int DATA_WIDTH      = 16000,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int PKTS_PER_BATCH  = 8,
  parameter int NUM_BANKS       = 2,
  parameter int FLUSH_TIMEOUT   = 1024
) (
  input  logic                         m_axis_c2h_aclk,
  input  logic                         m_axis_c2h_aresetn,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_c2h_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_c2h_tkeep,
  output logic                         m_axis_c2h_tlast,
  output logic                         m_axis_c2h_tvalid,
  input  logic                         m_axis_c2h_tready,
  input  logic [DATA_WIDTH-1:0]        data,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic                         flush,
  output logic [clog2_f(NUM_BANKS+1)-1:0] banks_full,
  output logic [31:0]                  batches_sent
);

  localparam int BEATS = beats_f(DATA_WIDTH, AXIS_DATA_WIDTH);
  localparam int IMG_W = BEATS * AXIS_DATA_WIDTH;
  localparam int BW    = clog2_f(NUM_BANKS);
  localparam int CW    = clog2_f(PKTS_PER_BATCH + 1);
  localparam int TW    = clog2_f(BEATS + 1);
  localparam int FW    = clog2_f(NUM_BANKS + 1);
  localparam logic [CW-1:0] PPB = CW'(PKTS_PER_BATCH);
  localparam bit ONE_BEAT = (BEATS == 1);

  logic                  clk;
  logic                  rst_n;
  logic [BW-1:0]         wr_bank;
  logic [BW-1:0]         rd_bank;
  logic [BW-1:0]         rbank;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         wr_cnt_n;
  logic [CW-1:0]         rd_idx;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         ridx;
  logic [CW:0]           ri;
  logic [CW-1:0]         cnt [NUM_BANKS];
  logic [NUM_BANKS-1:0]  sealed;
  logic [31:0]           idle_cnt;
  logic [3:0]            state;
  logic [TW-1:0]         beat_cnt;
  logic [7:0]            seq;
  logic [IMG_W-1:0]      sh;
  logic [IMG_W-1:0]      img;
  logic [DATA_WIDTH-1:0] rdata;
  logic accept, tmo_hit, seal, release_c;
  logic hs, last_beat, last_rec, next_last;
  logic ld, shift;

  assign clk   = m_axis_c2h_aclk;
  assign rst_n = m_axis_c2h_aresetn;

  assign data_ready = !sealed[wr_bank];
  assign accept     = data_valid && data_ready;
  assign wr_cnt_n   = wr_cnt + CW'(accept);
  assign tmo_hit    = (FLUSH_TIMEOUT != 0)
                   && (wr_cnt != '0) && !accept
                   && (idle_cnt == 32'(FLUSH_TIMEOUT - 1));
  assign seal       = (wr_cnt_n == PPB)
                   || ((flush || tmo_hit) && wr_cnt_n != '0);
  assign release_c  = state[REL_B];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank    <= '0;
      wr_cnt     <= '0;
      idle_cnt   <= '0;
      sealed     <= '0;
      banks_full <= '0;
      for (int b = 0; b < NUM_BANKS; b++) cnt[b] <= '0;
    end else begin
      if (accept || seal || wr_cnt == '0) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + 32'd1;
      if (seal) begin
        wr_cnt       <= '0;
        wr_bank      <= wr_bank + BW'(1);
        cnt[wr_bank] <= wr_cnt_n;
      end else begin
        wr_cnt <= wr_cnt_n;
      end
      // The read side only releases a sealed bank and the write
      // side only seals an open one, so the two never collide.
      if (release_c) sealed[rd_bank] <= 1'b0;
      if (seal) sealed[wr_bank] <= 1'b1;
      if (seal && !release_c) banks_full <= banks_full + FW'(1);
      else if (!seal && release_c) banks_full <= banks_full - FW'(1);
    end
  end

  assign rd_cnt    = cnt[rd_bank];
  assign hs        = m_axis_c2h_tvalid && m_axis_c2h_tready;
  assign last_beat = (beat_cnt == TW'(BEATS - 1));
  assign last_rec  = (rd_idx + CW'(1) == rd_cnt);
  assign next_last = (rd_idx + CW'(2) == rd_cnt);
  assign ld        = state[LOAD_B]
                  || (state[SEND_B] && hs && last_beat && !last_rec);
  assign shift     = state[SEND_B] && hs && !last_beat;

  always_comb begin
    img = '0;
    img[HDR_W-1:0] = seq;
    img[HDR_W +: DATA_WIDTH] = rdata;
  end

  // Read address follows the next state so rdata always holds the
  // record that the next load needs, enabling bubble-free chaining.
  always_comb begin
    rbank = rd_bank;
    ri    = '0;
    if (state[LOAD_B]) ri = (CW+1)'(1);
    else if (state[SEND_B]) ri = {1'b0, rd_idx} + (ld ? (CW+1)'(2) : (CW+1)'(1));
    else if (state[REL_B]) rbank = rd_bank + BW'(1);
    ridx = (ri >= {1'b0, PPB}) ? '0 : ri[CW-1:0];
  end

  batch_bank_store #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PKTS_PER_BATCH (PKTS_PER_BATCH),
    .NUM_BANKS      (NUM_BANKS),
    .BANK_W         (BW),
    .IDX_W          (CW)
  ) u_store (
    .clk   (clk),
    .we    (accept),
    .wbank (wr_bank),
    .widx  (wr_cnt),
    .wdata (data),
    .rbank (rbank),
    .ridx  (ridx),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (ld) sh <= img;
    else if (shift) sh <= sh >> AXIS_DATA_WIDTH;
  end

  assign m_axis_c2h_tdata = sh[AXIS_DATA_WIDTH-1:0];
  assign m_axis_c2h_tkeep = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      m_axis_c2h_tvalid <= 1'b0;
      m_axis_c2h_tlast  <= 1'b0;
      rd_bank           <= '0;
      rd_idx            <= '0;
      beat_cnt          <= '0;
      seq               <= '0;
      batches_sent      <= '0;
    end else begin
      unique case (1'b1)
        state[IDLE_B]: begin
          if (sealed[rd_bank]) state <= ST_LOAD;
        end
        state[LOAD_B]: begin
          rd_idx            <= '0;
          beat_cnt          <= '0;
          seq               <= seq + 8'd1;
          m_axis_c2h_tvalid <= 1'b1;
          m_axis_c2h_tlast  <= ONE_BEAT && (rd_cnt == CW'(1));
          state             <= ST_SEND;
        end
        state[SEND_B]: begin
          if (hs) begin
            if (last_beat && last_rec) begin
              m_axis_c2h_tvalid <= 1'b0;
              m_axis_c2h_tlast  <= 1'b0;
              state             <= ST_REL;
            end else if (last_beat) begin
              rd_idx           <= rd_idx + CW'(1);
              beat_cnt         <= '0;
              seq              <= seq + 8'd1;
              m_axis_c2h_tlast <= ONE_BEAT && next_last;
            end else begin
              beat_cnt         <= beat_cnt + TW'(1);
              m_axis_c2h_tlast <= last_rec
                && (beat_cnt + TW'(1) == TW'(BEATS - 1));
            end
          end
        end
        state[REL_B]: begin
          rd_bank      <= rd_bank + BW'(1);
          batches_sent <= batches_sent + 32'd1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
